// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one external 64-bit ALU between two requesters.
// Each accepted op runs IDLE/RESP -> EXEC -> RESP; illegal opcodes skip the ALU.
module alu_arbiter #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid0,
  output logic            req_ready0,
  input  logic [XLEN-1:0] req_a0,
  input  logic [XLEN-1:0] req_b0,
  input  logic [3:0]      req_op0,
  input  logic            req_valid1,
  output logic            req_ready1,
  input  logic [XLEN-1:0] req_a1,
  input  logic [XLEN-1:0] req_b1,
  input  logic [3:0]      req_op1,
  output logic            resp_valid0,
  output logic            resp_valid1,
  output logic [XLEN-1:0] resp_result,
  output logic            resp_zero,
  output logic            resp_err,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_op,
  input  logic [XLEN-1:0] alu_result,
  input  logic            alu_zero
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]            state;
  logic                  last_grant;
  logic                  owner;

  logic [1:0]            valid, ready, acc;
  logic [1:0][XLEN-1:0]  a, b;
  logic [1:0][3:0]       op;
  logic                  open_win;
  logic                  sel;

  assign valid = {req_valid1, req_valid0};
  assign a     = {req_a1, req_a0};
  assign b     = {req_b1, req_b0};
  assign op    = {req_op1, req_op0};

  // Ready is masked while reset is high so nothing looks accepted on a reset edge.
  assign open_win = (state != EXEC) && !reset;

  // A requester wins when it is alone, or when the other one was granted last.
  genvar g;
  generate
    for (g = 0; g < 2; g++) begin : g_grant
      assign ready[g] = open_win && valid[g] &&
                        (!valid[1-g] || (last_grant == 1'(1-g)));
    end
  endgenerate

  assign acc        = valid & ready;
  assign sel        = acc[1];
  assign req_ready0 = ready[0];
  assign req_ready1 = ready[1];

  assign resp_valid0 = (state == RESP) && !owner && !reset;
  assign resp_valid1 = (state == RESP) &&  owner && !reset;

  function automatic logic legal_op(input logic [3:0] o);
    return (o == 4'b0000) || (o == 4'b0001) || (o == 4'b0010) ||
           (o == 4'b0110) || (o == 4'b1100) || (o == 4'b1000);
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      last_grant  <= 1'b1;
      owner       <= 1'b0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_op      <= '0;
      resp_result <= '0;
      resp_zero   <= 1'b0;
      resp_err    <= 1'b0;
    end else if (state == EXEC) begin
      resp_result <= alu_result;
      resp_zero   <= alu_zero;
      resp_err    <= 1'b0;
      state       <= RESP;
    end else if (|acc) begin
      last_grant <= sel;
      owner      <= sel;
      if (legal_op(op[sel])) begin
        alu_a  <= a[sel];
        alu_b  <= b[sel];
        alu_op <= op[sel];
        state  <= EXEC;
      end else begin
        // The ALU keeps its previous operands; the error response is built here.
        resp_result <= '0;
        resp_zero   <= 1'b0;
        resp_err    <= 1'b1;
        state       <= RESP;
      end
    end else begin
      state <= IDLE;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: transaction-schedule model, directed
// scenarios with literal expectations, then randomized traffic with resets.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid0, req_valid1;
  logic        req_ready0, req_ready1;
  logic [63:0] req_a0, req_b0, req_a1, req_b1;
  logic [3:0]  req_op0, req_op1;
  logic        resp_valid0, resp_valid1;
  logic [63:0] resp_result;
  logic        resp_zero, resp_err;
  logic [63:0] alu_a, alu_b;
  logic [3:0]  alu_op;
  logic [63:0] alu_result;
  logic        alu_zero;

  int tests = 0;
  int fails = 0;

  alu_arbiter #(.XLEN(64)) dut (
    .clk(clk), .reset(reset),
    .req_valid0(req_valid0), .req_ready0(req_ready0), .req_a0(req_a0), .req_b0(req_b0), .req_op0(req_op0),
    .req_valid1(req_valid1), .req_ready1(req_ready1), .req_a1(req_a1), .req_b1(req_b1), .req_op1(req_op1),
    .resp_valid0(resp_valid0), .resp_valid1(resp_valid1),
    .resp_result(resp_result), .resp_zero(resp_zero), .resp_err(resp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_zero(alu_zero)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] alu_f(input logic [63:0] x, y, input logic [3:0] o);
    case (o)
      4'b0000: return x & y;
      4'b0001: return x | y;
      4'b0010: return x + y;
      4'b0110: return x - y;
      4'b1100: return ~(x | y);
      4'b1000: return ($signed(x) < $signed(y)) ? 64'd1 : 64'd0;
      default: return 64'd0;
    endcase
  endfunction

  function automatic bit is_legal(input logic [3:0] o);
    return o inside {4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b1100, 4'b1000};
  endfunction

  // External ALU
  always_comb begin
    alu_result = alu_f(alu_a, alu_b, alu_op);
    alu_zero   = (alu_result == 64'd0);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---- model: schedule of when the window is shut and when the response lands
  int          cyc = 0;
  int          m_block = -1;
  int          m_resp = -1;
  bit          m_last = 1'b1;
  bit          chk_en = 1'b0;
  logic [63:0] e_a = '0, e_b = '0, p_res = '0, h_res = '0;
  logic [3:0]  e_op = '0;
  bit          p_own, p_z, p_e, h_z, h_e;

  function automatic void mready(output bit r0, output bit r1);
    bit win;
    win = !reset && (cyc != m_block);
    r0  = win && req_valid0 && (!req_valid1 || m_last == 1'b1);
    r1  = win && req_valid1 && (!req_valid0 || m_last == 1'b0);
  endfunction

  task automatic accept(input bit id, input logic [63:0] x, y, input logic [3:0] o);
    m_last = id;
    p_own  = id;
    if (is_legal(o)) begin
      e_a = x; e_b = y; e_op = o;
      p_res = alu_f(x, y, o); p_z = (p_res == 64'd0); p_e = 1'b0;
      m_block = cyc + 1;
      m_resp  = cyc + 2;
    end else begin
      p_res = '0; p_z = 1'b0; p_e = 1'b1;
      m_resp = cyc + 1;
    end
  endtask

  always @(posedge clk) begin
    bit r0, r1;
    if (reset) begin
      chk_en = 1'b1;
      m_last = 1'b1; m_block = -1; m_resp = -1;
      e_a = '0; e_b = '0; e_op = '0;
      h_res = '0; h_z = 1'b0; h_e = 1'b0;
    end else if (chk_en) begin
      mready(r0, r1);
      if (req_valid0 && r0)      accept(1'b0, req_a0, req_b0, req_op0);
      else if (req_valid1 && r1) accept(1'b1, req_a1, req_b1, req_op1);
    end
    cyc++;
  end

  always @(negedge clk) begin
    bit r0, r1, rv;
    if (chk_en) begin
      mready(r0, r1);
      if (cyc == m_resp) begin
        h_res = p_res; h_z = p_z; h_e = p_e;
      end
      rv = !reset && (cyc == m_resp);
      chk("ready0", 64'(req_ready0), 64'(r0));
      chk("ready1", 64'(req_ready1), 64'(r1));
      chk("resp_valid0", 64'(resp_valid0), 64'(rv && !p_own));
      chk("resp_valid1", 64'(resp_valid1), 64'(rv && p_own));
      chk("resp_result", resp_result, h_res);
      chk("resp_zero", 64'(resp_zero), 64'(h_z));
      chk("resp_err", 64'(resp_err), 64'(h_e));
      chk("alu_a", alu_a, e_a);
      chk("alu_b", alu_b, e_b);
      chk("alu_op", 64'(alu_op), 64'(e_op));
      if (req_ready0 && req_ready1) chk("ready_exclusive", 64'd1, 64'd0);
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic logic [3:0] rand_legal();
    logic [3:0] t [6];
    t = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b1100, 4'b1000};
    return t[$urandom_range(5)];
  endfunction

  initial begin
    int acc_cnt, first_acc, last_acc, gcnt;
    bit gseq [8];

    reset = 1'b1;
    req_valid0 = 0; req_valid1 = 0;
    req_a0 = '0; req_b0 = '0; req_op0 = '0;
    req_a1 = '0; req_b1 = '0; req_op1 = '0;
    tick(); tick();
    @(negedge clk);
    chk("reset_ready0", 64'(req_ready0), 64'd0);
    chk("reset_alu_op", 64'(alu_op), 64'd0);
    chk("reset_result", resp_result, 64'd0);
    tick();
    reset = 1'b0;

    // add on requester 0
    req_valid0 = 1; req_a0 = 5; req_b0 = 7; req_op0 = 4'b0010;
    @(negedge clk); chk("add_ready0", 64'(req_ready0), 64'd1);
    tick(); req_valid0 = 0;
    @(negedge clk);
    chk("add_exec_op", 64'(alu_op), 64'd2);
    chk("add_exec_rv0", 64'(resp_valid0), 64'd0);
    @(negedge clk);
    chk("add_rv0", 64'(resp_valid0), 64'd1);
    chk("add_rv1", 64'(resp_valid1), 64'd0);
    chk("add_result", resp_result, 64'd12);
    chk("add_zero", 64'(resp_zero), 64'd0);
    chk("add_err", 64'(resp_err), 64'd0);

    // subtract to zero on requester 1
    tick();
    req_valid1 = 1; req_a1 = 64'h1234; req_b1 = 64'h1234; req_op1 = 4'b0110;
    @(negedge clk); chk("sub_ready1", 64'(req_ready1), 64'd1);
    tick(); req_valid1 = 0;
    @(negedge clk); @(negedge clk);
    chk("sub_rv1", 64'(resp_valid1), 64'd1);
    chk("sub_rv0", 64'(resp_valid0), 64'd0);
    chk("sub_result", resp_result, 64'd0);
    chk("sub_zero", 64'(resp_zero), 64'd1);

    // tie after reset
    tick(); reset = 1;
    tick(); reset = 0;
    req_valid0 = 1; req_a0 = 1; req_b0 = 1; req_op0 = 4'b0010;
    req_valid1 = 1; req_a1 = 2; req_b1 = 2; req_op1 = 4'b0010;
    @(negedge clk);
    chk("tie_ready0", 64'(req_ready0), 64'd1);
    chk("tie_ready1", 64'(req_ready1), 64'd0);
    tick(); req_valid0 = 0;
    @(negedge clk); chk("tie_exec_ready1", 64'(req_ready1), 64'd0);
    @(negedge clk);
    chk("tie_rv0", 64'(resp_valid0), 64'd1);
    chk("tie_res0", resp_result, 64'd2);
    chk("tie_ready1_resp", 64'(req_ready1), 64'd1);
    tick(); req_valid1 = 0;
    @(negedge clk); @(negedge clk);
    chk("tie_rv1", 64'(resp_valid1), 64'd1);
    chk("tie_res1", resp_result, 64'd4);

    // illegal op
    tick();
    req_valid0 = 1; req_a0 = 9; req_b0 = 9; req_op0 = 4'b1111;
    @(negedge clk); chk("ill_ready0", 64'(req_ready0), 64'd1);
    tick(); req_valid0 = 0;
    @(negedge clk);
    chk("ill_rv0", 64'(resp_valid0), 64'd1);
    chk("ill_result", resp_result, 64'd0);
    chk("ill_zero", 64'(resp_zero), 64'd0);
    chk("ill_err", 64'(resp_err), 64'd1);
    chk("ill_alu_op", 64'(alu_op), 64'd2);

    // reset during EXEC
    tick();
    req_valid1 = 1; req_a1 = 3; req_b1 = 4; req_op1 = 4'b0010;
    @(negedge clk);
    tick(); req_valid1 = 0; reset = 1;
    tick(); reset = 0;
    @(negedge clk);
    chk("rst_alu_op", 64'(alu_op), 64'd0);
    chk("rst_alu_a", alu_a, 64'd0);
    chk("rst_rv1", 64'(resp_valid1), 64'd0);
    chk("rst_err", 64'(resp_err), 64'd0);
    repeat (3) @(negedge clk);
    tick();
    req_valid0 = 1; req_a0 = 10; req_b0 = 20; req_op0 = 4'b0010;
    @(negedge clk); chk("post_rst_ready0", 64'(req_ready0), 64'd1);
    tick(); req_valid0 = 0;
    @(negedge clk); @(negedge clk);
    chk("post_rst_rv0", 64'(resp_valid0), 64'd1);
    chk("post_rst_res", resp_result, 64'd30);

    // back-to-back on requester 1, then fairness
    tick();
    req_valid1 = 1; req_a1 = {$urandom, $urandom}; req_b1 = {$urandom, $urandom}; req_op1 = rand_legal();
    acc_cnt = 0; first_acc = 0; last_acc = 0;
    for (int i = 0; i < 30 && acc_cnt < 6; i++) begin
      @(negedge clk);
      if (req_ready1) begin
        if (acc_cnt == 0) first_acc = i;
        last_acc = i;
        acc_cnt++;
      end
      tick();
      if (acc_cnt < 6) begin
        req_a1 = {$urandom, $urandom}; req_b1 = {$urandom, $urandom}; req_op1 = rand_legal();
      end
    end
    chk("b2b_count", 64'(acc_cnt), 64'd6);
    chk("b2b_span", 64'(last_acc - first_acc), 64'd10);
    req_valid0 = 1; req_a0 = {$urandom, $urandom}; req_b0 = {$urandom, $urandom}; req_op0 = rand_legal();
    gcnt = 0;
    for (int i = 0; i < 40 && gcnt < 6; i++) begin
      bit got0, got1;
      @(negedge clk);
      got0 = req_ready0; got1 = req_ready1;
      if (got0 || got1) begin gseq[gcnt] = got1; gcnt++; end
      tick();
      if (got0) begin req_a0 = {$urandom, $urandom}; req_b0 = {$urandom, $urandom}; req_op0 = rand_legal(); end
      if (got1) begin req_a1 = {$urandom, $urandom}; req_b1 = {$urandom, $urandom}; req_op1 = rand_legal(); end
    end
    chk("fair_count", 64'(gcnt), 64'd6);
    for (int i = 0; i < 6; i++) chk("fair_order", 64'(gseq[i]), 64'(i % 2));
    req_valid0 = 0; req_valid1 = 0;

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      tick();
      reset      = ($urandom_range(99) == 0);
      req_valid0 = ($urandom_range(9) < 6);
      req_valid1 = ($urandom_range(9) < 6);
      req_a0 = {$urandom, $urandom};
      req_b0 = ($urandom_range(7) == 0) ? req_a0 : {$urandom, $urandom};
      req_a1 = {$urandom, $urandom};
      req_b1 = ($urandom_range(7) == 0) ? req_a1 : {$urandom, $urandom};
      req_op0 = ($urandom_range(4) == 0) ? 4'($urandom) : rand_legal();
      req_op1 = ($urandom_range(4) == 0) ? 4'($urandom) : rand_legal();
    end
    tick();
    reset = 0; req_valid0 = 0; req_valid1 = 0;
    repeat (4) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
